// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, stall/bubble arbitration,
// multi-cycle mul/div hold and branch redirect with deferral behind an outstanding fetch.
module hazard_ctrl #(
  parameter int MD_LATENCY = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        use_rs1,
  input  logic        use_rs2,
  input  logic [4:0]  e_dst,
  input  logic        e_regwrite,
  input  logic        e_is_load,
  input  logic        e_multi_start,
  input  logic [4:0]  m_dst,
  input  logic        m_regwrite,
  input  logic [4:0]  w_dst,
  input  logic        w_regwrite,
  input  logic        e_redirect,
  input  logic [63:0] e_target,
  input  logic        i_busy,
  input  logic        d_busy,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall_f,
  output logic        stall_d,
  output logic        stall_e,
  output logic        stall_m,
  output logic        bubble_d,
  output logic        bubble_e,
  output logic        bubble_m,
  output logic        bubble_w,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] MD_BUSY = 1'b1;

  // The start cycle is one E cycle and the final md_cnt==0 cycle is another.
  localparam logic [5:0] MD_INIT = 6'(MD_LATENCY - 2);

  logic [0:0]  state;
  logic [5:0]  md_cnt;
  logic        pend;
  logic [63:0] pend_pc;

  logic        md_stall;
  logic        load_use;
  logic        hold_e;
  logic        accept;

  function automatic logic [1:0] fwd_sel(
    input logic       use_rs,
    input logic [4:0] ra,
    input logic       m_rw,
    input logic [4:0] m_d,
    input logic       w_rw,
    input logic [4:0] w_d
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_rs && ra != 5'd0) begin
      if (m_rw && m_d == ra)      sel = 2'b01;
      else if (w_rw && w_d == ra) sel = 2'b10;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(use_rs1, ra1, m_regwrite, m_dst, w_regwrite, w_dst);
  assign fwd_b = fwd_sel(use_rs2, ra2, m_regwrite, m_dst, w_regwrite, w_dst);

  assign md_stall = (state == RUN) ? e_multi_start : (md_cnt != 6'd0);
  assign load_use = e_is_load && e_regwrite && (e_dst != 5'd0) &&
                    ((use_rs1 && ra1 == e_dst) || (use_rs2 && ra2 == e_dst));
  assign hold_e   = d_busy || md_stall;
  assign accept   = e_redirect && !hold_e;

  always_comb begin
    stall_f        = 1'b0;
    stall_d        = 1'b0;
    stall_e        = 1'b0;
    stall_m        = 1'b0;
    bubble_d       = 1'b0;
    bubble_e       = 1'b0;
    bubble_m       = 1'b0;
    bubble_w       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 64'd0;

    if (d_busy) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      stall_m  = 1'b1;
      bubble_w = 1'b1;
    end else if (md_stall) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      stall_e  = 1'b1;
      bubble_m = 1'b1;
    end else if (load_use) begin
      stall_f  = 1'b1;
      stall_d  = 1'b1;
      bubble_e = 1'b1;
    end else if (i_busy) begin
      stall_f  = 1'b1;
      bubble_d = 1'b1;
    end

    // A taken redirect squashes D, so any load-use hold on D is moot.
    if (accept) begin
      stall_f  = i_busy;
      stall_d  = 1'b0;
      bubble_d = 1'b1;
      bubble_e = 1'b1;
    end

    if (pend && !stall_d)
      bubble_d = 1'b1;

    if (accept && !i_busy) begin
      redirect_valid = 1'b1;
      redirect_pc    = e_target;
    end else if (pend && !i_busy) begin
      redirect_valid = 1'b1;
      redirect_pc    = pend_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      md_cnt  <= 6'd0;
      pend    <= 1'b0;
      pend_pc <= 64'd0;
    end else begin
      case (state)
        RUN: begin
          if (e_multi_start && !d_busy) begin
            state  <= MD_BUSY;
            md_cnt <= MD_INIT;
          end
        end
        MD_BUSY: begin
          if (md_cnt == 6'd0) state  <= RUN;
          else                md_cnt <= md_cnt - 6'd1;
        end
        default: state <= RUN;
      endcase

      if (accept && i_busy) begin
        pend    <= 1'b1;
        pend_pc <= e_target;
      end else if (pend && !i_busy) begin
        pend    <= 1'b0;
      end
    end
  end

endmodule
